// File: rtl/etx_pkg.sv
// Shared constants, packet layout and arbitration helpers for the eLink TX arbiter.
package etx_pkg;

  localparam int AW = 32;
  localparam int PW = 104;

  // Packed packet layout; bit 7 is a spare slot between ctrlmode and dstaddr.
  localparam int WRITE_BIT    = 0;
  localparam int DATAMODE_LSB = 1;
  localparam int CTRLMODE_LSB = 3;
  localparam int DSTADDR_LSB  = 8;
  localparam int SRCADDR_LSB  = 40;
  localparam int DATA_LSB     = 72;

  localparam int CH_WR = 0;
  localparam int CH_RQ = 1;
  localparam int CH_RR = 2;
  localparam int NCH   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [2:0] fixed_pick(input logic [2:0] req);
    logic [2:0] win;
    if (req[CH_RR])      win = 3'b100;
    else if (req[CH_RQ]) win = 3'b010;
    else if (req[CH_WR]) win = 3'b001;
    else                 win = 3'b000;
    return win;
  endfunction

  // Walks downward so the candidate closest to start is the last one written.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
    logic [2:0] win;
    int idx;
    win = 3'b000;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NCH;
      if (req[idx]) win = 3'b001 << idx;
    end
    return win;
  endfunction

  function automatic logic [1:0] next_ch(input logic [2:0] grant);
    logic [1:0] nxt;
    case (grant)
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b100:  nxt = 2'd0;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/etx_arb_buf.sv
// One-entry holding buffer with full flag for a single eMesh requester channel.
module etx_arb_buf #(
  parameter int PW = etx_pkg::PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          access,
  input  logic [PW-1:0] packet,
  input  logic          clear,
  output logic          full,
  output logic [PW-1:0] pkt_out
);

  logic          full_q, full_d;
  logic [PW-1:0] pkt_q, pkt_d;

  // Load when empty; a grant empties the slot. Both can never coincide.
  always_comb begin
    full_d = full_q;
    pkt_d  = pkt_q;
    if (access && !full_q) begin
      full_d = 1'b1;
      pkt_d  = packet;
    end else if (clear) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      pkt_q  <= '0;
    end else begin
      full_q <= full_d;
      pkt_q  <= pkt_d;
    end
  end

  assign full    = full_q;
  assign pkt_out = pkt_q;

endmodule

// File: rtl/etx_arbiter.sv
// eLink TX arbiter: three buffered eMesh channels into the protocol encoder.
// Define ETX_ARB_RR_EN for round-robin; otherwise fixed priority rr > rq > wr.
module etx_arbiter #(
  parameter int AW = etx_pkg::AW,
  parameter int PW = etx_pkg::PW
) (
  input  logic          tx_lclk_par,
  input  logic          reset,
  input  logic          emwr_access,
  input  logic [PW-1:0] emwr_packet,
  output logic          emwr_wait,
  input  logic          emrq_access,
  input  logic [PW-1:0] emrq_packet,
  output logic          emrq_wait,
  input  logic          emrr_access,
  input  logic [PW-1:0] emrr_packet,
  output logic          emrr_wait,
  output logic          etx_access,
  output logic          etx_write,
  output logic [1:0]    etx_datamode,
  output logic [3:0]    etx_ctrlmode,
  output logic [AW-1:0] etx_dstaddr,
  output logic [AW-1:0] etx_srcaddr,
  output logic [AW-1:0] etx_data,
  input  logic          etx_ack,
  input  logic          etx_rd_wait,
  input  logic          etx_wr_wait,
  output logic [2:0]    etx_arb_grant
);
  import etx_pkg::*;

  logic [2:0]    acc_s, full_s, clr_s, elig_s, win_s;
  logic [PW-1:0] in_pkt_s [NCH];
  logic [PW-1:0] buf_pkt_s [NCH];
  logic [PW-1:0] sel_pkt_s;
  logic          take_s;

  state_t        state_q, state_d;
  logic          access_q, access_d;
  logic [2:0]    grant_q, grant_d;
  logic [PW-1:0] pkt_q, pkt_d;

  assign acc_s           = {emrr_access, emrq_access, emwr_access};
  assign in_pkt_s[CH_WR] = emwr_packet;
  assign in_pkt_s[CH_RQ] = emrq_packet;
  assign in_pkt_s[CH_RR] = emrr_packet;

  for (genvar i = 0; i < NCH; i++) begin : g_buf
    etx_arb_buf #(.PW(PW)) u_buf (
      .clk     (tx_lclk_par),
      .reset   (reset),
      .access  (acc_s[i]),
      .packet  (in_pkt_s[i]),
      .clear   (clr_s[i]),
      .full    (full_s[i]),
      .pkt_out (buf_pkt_s[i])
    );
  end

  assign emwr_wait = full_s[CH_WR];
  assign emrq_wait = full_s[CH_RQ];
  assign emrr_wait = full_s[CH_RR];

  // Remote waits gate eligibility only; an in-flight grant is never revoked.
  assign elig_s[CH_WR] = full_s[CH_WR] & ~etx_wr_wait;
  assign elig_s[CH_RQ] = full_s[CH_RQ] & ~etx_rd_wait;
  assign elig_s[CH_RR] = full_s[CH_RR] & ~etx_wr_wait;

`ifdef ETX_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  assign win_s = rr_pick(elig_s, ptr_q);

  // Pointer names the first channel searched; it moves past each winner.
  always_comb begin
    if (take_s) ptr_d = next_ch(win_s);
    else        ptr_d = ptr_q;
  end

  always_ff @(posedge tx_lclk_par) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  assign win_s = fixed_pick(elig_s);
`endif

  // One-hot AND-OR mux of the winning buffer.
  always_comb begin
    sel_pkt_s = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_pkt_s = sel_pkt_s | ({PW{win_s[i]}} & buf_pkt_s[i]);
    end
  end

  // Grant FSM: a new winner may be taken from IDLE or on the ack edge in BUSY.
  always_comb begin
    state_d  = state_q;
    access_d = access_q;
    grant_d  = grant_q;
    pkt_d    = pkt_q;
    clr_s    = 3'b000;
    take_s   = 1'b0;
    case (state_q)
      IDLE: take_s = |win_s;
      BUSY: begin
        if (etx_ack) begin
          if (|win_s) begin
            take_s = 1'b1;
          end else begin
            state_d  = IDLE;
            access_d = 1'b0;
            grant_d  = 3'b000;
          end
        end else begin
          take_s = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        access_d = 1'b0;
        grant_d  = 3'b000;
      end
    endcase
    if (take_s) begin
      state_d  = BUSY;
      access_d = 1'b1;
      grant_d  = win_s;
      pkt_d    = sel_pkt_s;
      clr_s    = win_s;
    end else begin
      clr_s    = 3'b000;
    end
  end

  always_ff @(posedge tx_lclk_par) begin
    if (reset) begin
      state_q  <= IDLE;
      access_q <= 1'b0;
      grant_q  <= 3'b000;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
      grant_q  <= grant_d;
      pkt_q    <= pkt_d;
    end
  end

  assign etx_access    = access_q;
  assign etx_arb_grant = grant_q;
  assign etx_write     = pkt_q[WRITE_BIT];
  assign etx_datamode  = pkt_q[DATAMODE_LSB +: 2];
  assign etx_ctrlmode  = pkt_q[CTRLMODE_LSB +: 4];
  assign etx_dstaddr   = pkt_q[DSTADDR_LSB +: AW];
  assign etx_srcaddr   = pkt_q[SRCADDR_LSB +: AW];
  assign etx_data      = pkt_q[DATA_LSB +: AW];

endmodule

// File: tb/tb_etx_arbiter.sv
// Scoreboard bench for etx_arbiter with a small encoder model driving etx_ack.
module tb_etx_arbiter;
  import etx_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          emwr_access = 1'b0, emrq_access = 1'b0, emrr_access = 1'b0;
  logic [PW-1:0] emwr_packet = '0, emrq_packet = '0, emrr_packet = '0;
  logic          emwr_wait, emrq_wait, emrr_wait;
  logic          etx_access, etx_write;
  logic [1:0]    etx_datamode;
  logic [3:0]    etx_ctrlmode;
  logic [31:0]   etx_dstaddr, etx_srcaddr, etx_data;
  logic          etx_ack = 1'b0, etx_rd_wait = 1'b0, etx_wr_wait = 1'b0;
  logic [2:0]    etx_arb_grant;

  etx_arbiter dut (
    .tx_lclk_par(clk), .reset(reset),
    .emwr_access(emwr_access), .emwr_packet(emwr_packet), .emwr_wait(emwr_wait),
    .emrq_access(emrq_access), .emrq_packet(emrq_packet), .emrq_wait(emrq_wait),
    .emrr_access(emrr_access), .emrr_packet(emrr_packet), .emrr_wait(emrr_wait),
    .etx_access(etx_access), .etx_write(etx_write), .etx_datamode(etx_datamode),
    .etx_ctrlmode(etx_ctrlmode), .etx_dstaddr(etx_dstaddr), .etx_srcaddr(etx_srcaddr),
    .etx_data(etx_data), .etx_ack(etx_ack), .etx_rd_wait(etx_rd_wait),
    .etx_wr_wait(etx_wr_wait), .etx_arb_grant(etx_arb_grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    g;
    logic [PW-1:0] p;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] mkpkt(input logic w, input logic [1:0] dm, input logic [3:0] cm,
                                          input logic [31:0] dst, input logic [31:0] src,
                                          input logic [31:0] dat);
    logic [PW-1:0] p;
    p = '0;
    p[WRITE_BIT] = w;
    p[DATAMODE_LSB +: 2] = dm;
    p[CTRLMODE_LSB +: 4] = cm;
    p[DSTADDR_LSB +: 32] = dst;
    p[SRCADDR_LSB +: 32] = src;
    p[DATA_LSB +: 32] = dat;
    return p;
  endfunction

  function automatic logic [102:0] flds(input logic [PW-1:0] p);
    return {p[WRITE_BIT], p[DATAMODE_LSB +: 2], p[CTRLMODE_LSB +: 4],
            p[DSTADDR_LSB +: 32], p[SRCADDR_LSB +: 32], p[DATA_LSB +: 32]};
  endfunction

  function automatic exp_t mkexp(input logic [2:0] g, input logic [PW-1:0] p);
    exp_t e;
    e.g = g;
    e.p = p;
    return e;
  endfunction

  // Encoder model: ack for one cycle, the cycle after access is first seen.
  initial begin
    logic nxt;
    forever begin
      @(negedge clk); #1;
      nxt = etx_access && !etx_ack && !reset;
      @(posedge clk); #1;
      etx_ack = nxt;
    end
  end

  initial forever begin
    @(negedge clk);
    cycle_cnt++;
  end

  // Monitor: a transaction starts when access rises or continues past an ack edge.
  initial begin
    logic prev_access, prev_ack, have_cur;
    exp_t cur;
    prev_access = 1'b0; prev_ack = 1'b0; have_cur = 1'b0; cur = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        prev_access = 1'b0;
        prev_ack = 1'b0;
        have_cur = 1'b0;
      end else begin
        if (etx_access && (!prev_access || prev_ack)) begin
          if (q.size() == 0) begin
            chk("unexpected_txn", {125'd0, etx_arb_grant}, 128'd0);
            have_cur = 1'b0;
          end else begin
            cur = q.pop_front();
            have_cur = 1'b1;
            chk("txn_grant", {125'd0, etx_arb_grant}, {125'd0, cur.g});
            chk("txn_fields", {25'd0, etx_write, etx_datamode, etx_ctrlmode, etx_dstaddr,
                               etx_srcaddr, etx_data}, {25'd0, flds(cur.p)});
          end
        end else if (etx_access && have_cur) begin
          chk("fields_stable", {25'd0, etx_write, etx_datamode, etx_ctrlmode, etx_dstaddr,
                                etx_srcaddr, etx_data}, {25'd0, flds(cur.p)});
        end else begin
          have_cur = have_cur;
        end
        prev_access = etx_access;
        prev_ack = etx_ack;
      end
    end
  end

  // Present packets on the masked channels for exactly one edge; returns at the next negedge.
  task automatic load3(input logic [2:0] m, input logic [PW-1:0] pw, input logic [PW-1:0] pq,
                       input logic [PW-1:0] pr);
    @(negedge clk);
    chk("load_waits_low", {125'd0, emrr_wait, emrq_wait, emwr_wait} & {125'd0, m}, 128'd0);
    emwr_access = m[0]; emwr_packet = pw;
    emrq_access = m[1]; emrq_packet = pq;
    emrr_access = m[2]; emrr_packet = pr;
    @(negedge clk);
    emwr_access = 1'b0; emrq_access = 1'b0; emrr_access = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!etx_access && q.size() == 0) done = 1'b1;
    end
    chk("idle_reached", {127'd0, done}, 128'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Holds emwr_access until the buffer accepts; reports the accept cycle.
  task automatic send_wr(input logic [PW-1:0] p, output int cyc);
    logic w, ok;
    ok = 1'b0;
    cyc = -1;
    emwr_access = 1'b1;
    emwr_packet = p;
    for (int i = 0; i < 20 && !ok; i++) begin
      w = emwr_wait;
      @(posedge clk);
      if (!w) begin
        ok = 1'b1;
        cyc = cycle_cnt;
      end
      @(negedge clk);
    end
    chk("send_accepted", {127'd0, ok}, 128'd1);
  endtask

  logic [PW-1:0] pw1, pw2, pq1, pr1, pw3, pq3;
  logic [2:0]    ord [3];
  int            c1, c2;

  initial begin
    pw1 = mkpkt(1'b1, 2'b10, 4'h0, 32'h8080_0000, 32'h0000_0000, 32'hDEAD_BEEF);
    pw2 = mkpkt(1'b1, 2'b01, 4'h3, 32'h1234_5678, 32'hA5A5_0001, 32'h0BAD_F00D);
    pq1 = mkpkt(1'b0, 2'b10, 4'h5, 32'h8090_0010, 32'h8100_0020, 32'h0000_0000);
    pr1 = mkpkt(1'b1, 2'b11, 4'hA, 32'h8100_0020, 32'h0000_0000, 32'hCAFE_0123);
    pw3 = mkpkt(1'b1, 2'b00, 4'hF, 32'hFFFF_FFFC, 32'h5555_AAAA, 32'h1357_9BDF);
    pq3 = mkpkt(1'b0, 2'b01, 4'h1, 32'h0000_0004, 32'h8200_0000, 32'h0000_0000);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_access", {127'd0, etx_access}, 128'd0);
    chk("rst_grant", {125'd0, etx_arb_grant}, 128'd0);
    chk("rst_waits", {125'd0, emrr_wait, emrq_wait, emwr_wait}, 128'd0);
    chk("rst_fields", {25'd0, etx_write, etx_datamode, etx_ctrlmode, etx_dstaddr, etx_srcaddr,
                       etx_data}, 128'd0);

    // Single write: accept at A, access from A+1, completion at A+3.
    q.push_back(mkexp(3'b001, pw1));
    load3(3'b001, pw1, '0, '0);
    chk("sw_wait_after_accept", {127'd0, emwr_wait}, 128'd1);
    chk("sw_access_a", {127'd0, etx_access}, 128'd0);
    @(negedge clk);
    chk("sw_access_a1", {127'd0, etx_access}, 128'd1);
    chk("sw_grant_a1", {125'd0, etx_arb_grant}, {125'd0, 3'b001});
    chk("sw_wait_freed", {127'd0, emwr_wait}, 128'd0);
    @(negedge clk);
    chk("sw_access_a2", {127'd0, etx_access}, 128'd1);
    @(negedge clk);
    chk("sw_access_done", {127'd0, etx_access}, 128'd0);
    chk("sw_grant_done", {125'd0, etx_arb_grant}, 128'd0);
    chk("sw_dst_held", {96'd0, etx_dstaddr}, {96'd0, 32'h8080_0000});
    chk("sw_data_held", {96'd0, etx_data}, {96'd0, 32'hDEAD_BEEF});

    // All three channels loaded together, straight after reset.
    apply_reset();
`ifdef ETX_ARB_RR_EN
    ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100;
`else
    ord[0] = 3'b100; ord[1] = 3'b010; ord[2] = 3'b001;
`endif
    for (int k = 0; k < 3; k++) begin
      q.push_back(mkexp(ord[k], ord[k] == 3'b001 ? pw2 : (ord[k] == 3'b010 ? pq1 : pr1)));
    end
    load3(3'b111, pw2, pq1, pr1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("b2b_access", {127'd0, etx_access}, 128'd1);
      chk("b2b_grant", {125'd0, etx_arb_grant}, {125'd0, ord[k/2]});
    end
    @(negedge clk);
    chk("b2b_end_access", {127'd0, etx_access}, 128'd0);
    chk("b2b_end_grant", {125'd0, etx_arb_grant}, 128'd0);

    // Read wait blocks a lone rq; releasing it grants on the next edge.
    etx_rd_wait = 1'b1;
    load3(3'b010, '0, pq3, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rdw_no_access", {127'd0, etx_access}, 128'd0);
      chk("rdw_rq_wait", {127'd0, emrq_wait}, 128'd1);
    end
    q.push_back(mkexp(3'b010, pq3));
    etx_rd_wait = 1'b0;
    @(negedge clk);
    chk("rdw_release_grant", {125'd0, etx_arb_grant}, {125'd0, 3'b010});
    wait_idle();

    // Write wait holds wr while rq goes; a read wait raised mid-transaction does not abort it.
    etx_wr_wait = 1'b1;
    q.push_back(mkexp(3'b010, pq1));
    load3(3'b011, pw3, pq1, '0);
    @(negedge clk);
    chk("wrw_grant_rq", {125'd0, etx_arb_grant}, {125'd0, 3'b010});
    etx_rd_wait = 1'b1;
    @(negedge clk);
    chk("wrw_busy_holds", {127'd0, etx_access}, 128'd1);
    @(negedge clk);
    chk("wrw_done", {127'd0, etx_access}, 128'd0);
    chk("wrw_wr_held", {127'd0, emwr_wait}, 128'd1);
    repeat (2) @(negedge clk);
    chk("wrw_still_idle", {127'd0, etx_access}, 128'd0);
    q.push_back(mkexp(3'b001, pw3));
    etx_wr_wait = 1'b0;
    etx_rd_wait = 1'b0;
    wait_idle();

    // Requester holding access across wait: one accept per packet, second two cycles later.
    q.push_back(mkexp(3'b001, pw1));
    q.push_back(mkexp(3'b001, pw2));
    send_wr(pw1, c1);
    send_wr(pw2, c2);
    emwr_access = 1'b0;
    chk("hold_accept_gap", c2 - c1, 128'd2);
    wait_idle();

    // Reset in the middle of a transaction with the other buffers still full.
    apply_reset();
`ifdef ETX_ARB_RR_EN
    q.push_back(mkexp(3'b001, pw2));
`else
    q.push_back(mkexp(3'b100, pr1));
`endif
    load3(3'b111, pw2, pq1, pr1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_access", {127'd0, etx_access}, 128'd0);
    chk("mrst_grant", {125'd0, etx_arb_grant}, 128'd0);
    chk("mrst_waits", {125'd0, emrr_wait, emrq_wait, emwr_wait}, 128'd0);
    chk("mrst_dst", {96'd0, etx_dstaddr}, 128'd0);
    repeat (3) @(negedge clk);
    chk("mrst_stays_idle", {127'd0, etx_access}, 128'd0);
    q.push_back(mkexp(3'b010, pq3));
    load3(3'b010, '0, pq3, '0);
    wait_idle();

    chk("queue_drained", q.size(), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
